// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//
// Memory-mapped LED sequencer. The CPU programs a pattern, a display mode and
// a step period. The block then drives the board LEDs directly, blinks them,
// rotates them left or bounces a pattern back and forth. All movement is paced
// by an internal prescaler that produces one "tick" every PERIOD clock edges.
//
// Optional feature macro: LED_PATTERN_CTRL_BOUNCE_EN
//   defined   -> mode 3 bounces the working pattern, and the bounce
//                direction is reported in STATUS bit 30
//   undefined -> mode 3 displays PATTERN exactly like mode 0, no direction
//                state exists, and STATUS bit 30 reads 0
//
// Ports
//   clk         in   1      system clock, all state changes on rising edge
//   rst         in   1      synchronous active-high reset
//   LEDCtrl     in   1      MMIO write strobe for this block
//   addr        in   2      0 PATTERN, 1 MODE, 2 PERIOD, 3 STATUS (read-only)
//   write_data  in   32     CPU store data
//   read_data   out  32     combinational readback of the selected register
//   led_data    out  LED_W  registered LED drive
// ---------------------------------------------------------------------------
module led_pattern_ctrl #(
  parameter int LED_W = 16,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LEDCtrl,
  input  logic [1:0]       addr,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] led_data
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;

  // Programmable registers
  logic [LED_W-1:0] pattern_q, pattern_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] period_q, period_d;

  // Sequencing state
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] work_q, work_d;
  logic             phase_q, phase_d;
  logic [15:0]      steps_q, steps_d;
  logic [LED_W-1:0] led_q, led_d;

  logic [DIV_W-1:0] periodEff;
  logic             wrEn;
  logic             tick;
  logic             dirBit;

  // Store data above the widest register field never reaches any state.
  logic unused_wdata;
  assign unused_wdata = ^write_data[31:DIV_W];

`ifdef LED_PATTERN_CTRL_BOUNCE_EN
  logic dir_q, dir_d;
  assign dirBit = dir_q;
`else
  assign dirBit = 1'b0;
`endif

  // A period of 0 is treated as 1 so the prescaler always has a valid
  // terminal count and ticks on every edge.
  assign periodEff = (period_q == '0) ? DIV_W'(1) : period_q;
  assign tick      = (cnt_q == (periodEff - DIV_W'(1)));

  // Writes to STATUS are dropped completely: no register update and no
  // restart of the sequence.
  assign wrEn = LEDCtrl && (addr != 2'd3);

  // Next-state logic. A write always has priority over a tick that falls on
  // the same edge: the sequence restarts from the (possibly new) pattern and
  // the tick is lost.
  always_comb begin
    pattern_d = pattern_q;
    mode_d    = mode_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    phase_d   = phase_q;
    steps_d   = steps_q;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
    dir_d     = dir_q;
`endif

    if (wrEn) begin
      case (addr)
        ADDR_PATTERN: pattern_d = write_data[LED_W-1:0];
        ADDR_MODE:    mode_d    = mode_e'(write_data[1:0]);
        ADDR_PERIOD:  period_d  = write_data[DIV_W-1:0];
        default:      ;
      endcase
      cnt_d   = '0;
      phase_d = 1'b0;
      steps_d = '0;
      // work reloads from the pattern as it will be after this write
      work_d  = pattern_d;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      dir_d   = 1'b0;
`endif
    end else if (tick) begin
      cnt_d   = '0;
      steps_d = steps_q + 16'd1;
      case (mode_q)
        MODE_BLINK:  phase_d = ~phase_q;
        MODE_ROTATE: work_d  = {work_q[LED_W-2:0], work_q[LED_W-1]};
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
        MODE_BOUNCE: begin
          // Reverse when the leading edge of the pattern reaches the end it
          // is travelling towards; the reversing tick already moves one step
          // back the other way.
          if (!dir_q) begin
            if (work_q[LED_W-1]) begin
              dir_d  = 1'b1;
              work_d = work_q >> 1;
            end else begin
              work_d = work_q << 1;
            end
          end else begin
            if (work_q[0]) begin
              dir_d  = 1'b0;
              work_d = work_q << 1;
            end else begin
              work_d = work_q >> 1;
            end
          end
        end
`endif
        default: ;
      endcase
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // LED drive is derived from next-state values so a write or tick shows on
  // the LEDs on the very edge it happens.
  always_comb begin
    led_d = pattern_d;
    case (mode_d)
      MODE_BLINK:  led_d = phase_d ? '0 : pattern_d;
      MODE_ROTATE: led_d = work_d;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      MODE_BOUNCE: led_d = work_d;
`endif
      default:     ;
    endcase
  end

  // CPU readback multiplexer
  always_comb begin
    read_data = '0;
    case (addr)
      ADDR_PATTERN: read_data = 32'(pattern_q);
      ADDR_MODE:    read_data = {30'b0, mode_q};
      ADDR_PERIOD:  read_data = 32'(period_q);
      default:      read_data = {phase_q, dirBit, 14'b0, steps_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      mode_q    <= MODE_DIRECT;
      period_q  <= '0;
      cnt_q     <= '0;
      work_q    <= '0;
      phase_q   <= 1'b0;
      steps_q   <= '0;
      led_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      phase_q   <= phase_d;
      steps_q   <= steps_d;
      led_q     <= led_d;
    end
  end

`ifdef LED_PATTERN_CTRL_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign led_data = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Self-checking bench for led_pattern_ctrl. The reference model tracks the
// programmed registers plus the number of clock edges since the last write
// or reset; tick count, blink phase, step count and rotation are all derived
// arithmetically from that edge count. Only the bounce position is advanced
// tick by tick. Honours LED_PATTERN_CTRL_BOUNCE_EN like the design.
// ---------------------------------------------------------------------------
module tb_led_pattern_ctrl;

`ifdef LED_PATTERN_CTRL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ledCtrl = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic [15:0] ledData;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] mPattern = 16'd0;
  logic [1:0]  mMode = 2'd0;
  logic [23:0] mPeriod = 24'd0;
  longint      mSince = 0;
  logic [15:0] mWork = 16'd0;
  logic        mDir = 1'b0;

  always #5 clk = ~clk;

  led_pattern_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .LEDCtrl    (ledCtrl),
    .addr       (addr),
    .write_data (writeData),
    .read_data  (readData),
    .led_data   (ledData)
  );

  function automatic longint effPeriod();
    return (mPeriod == 24'd0) ? 64'd1 : longint'(mPeriod);
  endfunction

  function automatic longint ticks();
    return mSince / effPeriod();
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] p, input int n);
    logic [31:0] d;
    d = {p, p} << n;
    return d[31:16];
  endfunction

  function automatic logic expPhase();
    longint t;
    t = ticks();
    return (mMode == 2'd1) ? t[0] : 1'b0;
  endfunction

  function automatic logic [15:0] expLed();
    longint t;
    t = ticks();
    case (mMode)
      2'd0:    return mPattern;
      2'd1:    return expPhase() ? 16'h0000 : mPattern;
      2'd2:    return rotl(mPattern, int'(t % 16));
      default: return BOUNCE ? mWork : mPattern;
    endcase
  endfunction

  function automatic logic [31:0] expRead(input logic [1:0] a);
    longint t;
    t = ticks();
    case (a)
      2'd0:    return {16'b0, mPattern};
      2'd1:    return {30'b0, mMode};
      2'd2:    return {8'b0, mPeriod};
      default: return {expPhase(), (BOUNCE ? mDir : 1'b0), 14'b0, t[15:0]};
    endcase
  endfunction

  // One clock edge: wait for it, update the model from the inputs that were
  // presented at it, then return at the falling edge for checking/driving.
  task automatic step();
    longint p;
    @(posedge clk);
    p = effPeriod();
    if (rst) begin
      mPattern = 16'd0;
      mMode    = 2'd0;
      mPeriod  = 24'd0;
      mSince   = 0;
      mWork    = 16'd0;
      mDir     = 1'b0;
    end else if (ledCtrl && addr != 2'd3) begin
      case (addr)
        2'd0:    mPattern = writeData[15:0];
        2'd1:    mMode = writeData[1:0];
        default: mPeriod = writeData[23:0];
      endcase
      mSince = 0;
      mWork  = mPattern;
      mDir   = 1'b0;
    end else begin
      mSince++;
      if ((mSince % p) == 0 && mMode == 2'd3 && BOUNCE) begin
        if (!mDir && mWork[15]) begin
          mDir = 1'b1;
          mWork = mWork >> 1;
        end else if (!mDir) begin
          mWork = mWork << 1;
        end else if (mWork[0]) begin
          mDir = 1'b0;
          mWork = mWork << 1;
        end else begin
          mWork = mWork >> 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic doWrite(input logic [1:0] a, input logic [31:0] d);
    ledCtrl   = 1'b1;
    addr      = a;
    writeData = d;
    step();
    ledCtrl   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (ledData !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_led: got %h expected 0000", ledData);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      total++;
      if (readData !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_read addr %0d: got %h expected 00000000", a, readData);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    doWrite(2'd0, 32'h0000_A5A5);
    total++;
    if (ledData !== 16'hA5A5) begin
      bad++;
      $display("[TB] FAIL direct_led: got %h expected a5a5", ledData);
    end
    addr = 2'd0;
    #1;
    total++;
    if (readData !== 32'h0000_A5A5) begin
      bad++;
      $display("[TB] FAIL direct_read: got %h expected 0000a5a5", readData);
    end
    doWrite(2'd0, 32'hFFFF_1234);
    total++;
    if (readData !== 32'h0000_1234 || ledData !== 16'h1234) begin
      bad++;
      $display("[TB] FAIL direct_mask: got read %h led %h expected 00001234/1234", readData, ledData);
    end
  endtask

  task automatic test_blink();
    doWrite(2'd2, 32'd4);
    doWrite(2'd1, 32'd1);
    doWrite(2'd0, 32'h0000_00FF);
    addr = 2'd3;
    for (int c = 1; c <= 16; c++) begin
      step();
      total++;
      if (ledData !== expLed()) begin
        bad++;
        $display("[TB] FAIL blink_led cyc %0d: got %h expected %h", c, ledData, expLed());
      end
      if (c == 4 || c == 8) begin
        total++;
        if (ledData !== ((c == 4) ? 16'h0000 : 16'h00FF)) begin
          bad++;
          $display("[TB] FAIL blink_edge cyc %0d: got %h", c, ledData);
        end
      end
      if (c == 12) begin
        total++;
        if (readData !== 32'h8000_0003) begin
          bad++;
          $display("[TB] FAIL blink_status: got %h expected 80000003", readData);
        end
      end
    end
  endtask

  task automatic test_rotate();
    logic [15:0] want [4];
    want = '{16'h0003, 16'h0006, 16'h000C, 16'h8001};
    doWrite(2'd2, 32'd1);
    doWrite(2'd1, 32'd2);
    doWrite(2'd0, 32'h0000_8001);
    for (int c = 1; c <= 16; c++) begin
      step();
      total++;
      if (ledData !== expLed()) begin
        bad++;
        $display("[TB] FAIL rotate_led cyc %0d: got %h expected %h", c, ledData, expLed());
      end
      if (c <= 3 || c == 16) begin
        total++;
        if (ledData !== want[(c == 16) ? 3 : c - 1]) begin
          bad++;
          $display("[TB] FAIL rotate_fixed cyc %0d: got %h expected %h", c, ledData,
                   want[(c == 16) ? 3 : c - 1]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    doWrite(2'd2, 32'd1);
    doWrite(2'd1, 32'd3);
    doWrite(2'd0, 32'h0000_4000);
    addr = 2'd3;
    for (int c = 1; c <= 20; c++) begin
      step();
      total++;
      if (ledData !== expLed() || readData !== expRead(2'd3)) begin
        bad++;
        $display("[TB] FAIL bounce_model cyc %0d: got led %h status %h expected %h %h",
                 c, ledData, readData, expLed(), expRead(2'd3));
      end
      if (BOUNCE) begin
        if (c == 1 || c == 2 || c == 16 || c == 17) begin
          total++;
          if ((c == 1 && ledData !== 16'h8000) ||
              (c == 2 && (ledData !== 16'h4000 || readData[30] !== 1'b1)) ||
              (c == 16 && ledData !== 16'h0001) ||
              (c == 17 && (ledData !== 16'h0002 || readData[30] !== 1'b0))) begin
            bad++;
            $display("[TB] FAIL bounce_fixed cyc %0d: got led %h dir %b", c, ledData, readData[30]);
          end
        end
      end else begin
        total++;
        if (ledData !== 16'h4000 || readData[30] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL bounce_off cyc %0d: got led %h dir %b expected 4000 0", c, ledData,
                   readData[30]);
        end
      end
    end
  endtask

  task automatic test_collision();
    doWrite(2'd2, 32'd3);
    doWrite(2'd1, 32'd2);
    doWrite(2'd0, 32'h0000_0001);
    step();
    step();
    doWrite(2'd0, 32'h0000_0010);
    addr = 2'd3;
    #1;
    total++;
    if (ledData !== 16'h0010 || readData[15:0] !== 16'd0) begin
      bad++;
      $display("[TB] FAIL collision_write: got led %h steps %h expected 0010 0000", ledData,
               readData[15:0]);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if (ledData !== expLed() || ledData !== ((c == 3) ? 16'h0020 : 16'h0010)) begin
        bad++;
        $display("[TB] FAIL collision_after cyc %0d: got %h expected %h", c, ledData, expLed());
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (r < 30) begin
        r = int'($urandom_range(0, 3));
        if (r == 2) doWrite(2'd2, $urandom_range(0, 4) | ($urandom & 32'hFF00_0000));
        else if (r == 1) doWrite(2'd1, $urandom);
        else doWrite(2'(r), $urandom);
      end else begin
        step();
      end
      addr = 2'($urandom_range(0, 3));
      #1;
      total++;
      if (ledData !== expLed() || readData !== expRead(addr)) begin
        bad++;
        $display("[TB] FAIL random it %0d addr %0d: got led %h read %h expected %h %h",
                 i, addr, ledData, readData, expLed(), expRead(addr));
      end
    end
  endtask

  task automatic test_reset_mid();
    doWrite(2'd2, 32'd1);
    doWrite(2'd1, 32'd2);
    doWrite(2'd0, 32'h0000_8001);
    step();
    step();
    step();
    rst       = 1'b1;
    ledCtrl   = 1'b1;
    addr      = 2'd0;
    writeData = 32'h0000_FFFF;
    step();
    ledCtrl = 1'b0;
    #1;
    total++;
    if (ledData !== 16'h0000 || readData !== 32'h0) begin
      bad++;
      $display("[TB] FAIL resetmid_now: got led %h pattern %h expected 0000 0", ledData, readData);
    end
    addr = 2'd1;
    #1;
    total++;
    if (readData !== 32'h0) begin
      bad++;
      $display("[TB] FAIL resetmid_mode: got %h expected 00000000", readData);
    end
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      total++;
      if (ledData !== 16'h0000) begin
        bad++;
        $display("[TB] FAIL resetmid_hold cyc %0d: got %h expected 0000", c, ledData);
      end
    end
  endtask

  task automatic test_wrap();
    doWrite(2'd1, 32'd1);
    doWrite(2'd2, 32'd1);
    addr = 2'd3;
    repeat (65535) step();
    total++;
    if (readData !== 32'h8000_FFFF || readData !== expRead(2'd3)) begin
      bad++;
      $display("[TB] FAIL wrap_before: got %h expected 8000ffff", readData);
    end
    step();
    total++;
    if (readData !== 32'h0000_0000 || readData !== expRead(2'd3)) begin
      bad++;
      $display("[TB] FAIL wrap_after: got %h expected 00000000", readData);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_direct();
    test_blink();
    test_rotate();
    test_bounce();
    test_collision();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Memory-mapped LED sequencer between the CPU's MMIO write/read path and the 16 board LEDs. It replaces a plain LED latch with a small programmable engine. The CPU writes a pattern, a mode and a step period. The block then drives `led_data` directly, blinks it, rotates it, or (optionally) bounces it, using an internal prescaler.

## Interface
- `LED_W`, 16, LED count and width of the pattern, work and output registers.
- `DIV_W`, 24, width of the period register and the prescaler counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `LEDCtrl`  in  1  MMIO write strobe for this block, sampled on the rising edge.
- `addr`  in  2  register select: 0 PATTERN, 1 MODE, 2 PERIOD, 3 STATUS (read-only).
- `write_data`  in  32  CPU store data.
- `read_data`  out  32  combinational readback of the register selected by `addr`.
- `led_data`  out  LED_W  registered LED drive.

## Operation
- Registers:
  - PATTERN = `write_data[LED_W-1:0]`.
  - MODE = `write_data[1:0]`: 0 direct, 1 blink, 2 rotate-left, 3 bounce.
  - PERIOD = `write_data[DIV_W-1:0]`.
- Internal state:
  - `cnt` (DIV_W): prescaler counter.
  - `work` (LED_W): working pattern.
  - `phase` (1 bit): blink phase.
  - `dir` (1 bit): 0 = left, 1 = right.
  - `steps` (16 bits): tick counter.
- Tick generation:
  - Effective period P = max(PERIOD, 1).
  - `tick` = (`cnt` == P-1); on tick `cnt` <= 0, else `cnt` <= `cnt`+1.
- Any write (`LEDCtrl`=1, `addr` 0..2):
  - Updates the addressed register.
  - Sets `cnt`, `phase`, `dir`, `steps` to 0.
  - Sets `work` to the resulting PATTERN value (the new value when `addr`=0).
  - A write to `addr` 3 is ignored entirely.
- On tick with no write:
  - `steps` <= `steps`+1, wrapping at 16'hFFFF -> 0.
  - Mode 0: no state change beyond `steps`.
  - Mode 1: `phase` toggles.
  - Mode 2: `work` rotates left by 1, so bit LED_W-1 moves to bit 0.
  - Mode 3, `dir`=0: if `work[LED_W-1]` is set, then `dir` <= 1 and `work` <= `work`>>1; otherwise `work` <= `work`<<1.
  - Mode 3, `dir`=1: if `work[0]` is set, then `dir` <= 0 and `work` <= `work`<<1; otherwise `work` <= `work`>>1.
  - Mode 3 shifts are logical. `work`=0 stays 0.
- `led_data` next value:
  - Mode 0: PATTERN.
  - Mode 1: `phase` ? 0 : PATTERN.
  - Modes 2 and 3: `work`.
  - `led_data` is computed from next-state values, so it reflects a write or tick on the same edge.
- `read_data` by `addr`:
  - 0: zero-extended PATTERN.
  - 1: {30'b0, MODE}.
  - 2: zero-extended PERIOD.
  - 3: {`phase`, `dir`, 14'b0, `steps`}.

## Timing
- Reset at a rising edge with `rst`=1:
  - PATTERN, MODE, PERIOD, `cnt`, `work`, `phase`, `dir`, `steps` and `led_data` all become 0.
  - `read_data` then reads 0 at every address.
- Reset mid-operation aborts any sequence. An asserted reset overrides a simultaneous `LEDCtrl`.
- Write latency: a write sampled at edge N is visible on `led_data` and `read_data` after edge N.
- First tick after a write occurs at edge N+P (counting edges after N). Subsequent ticks occur every P edges.
- Write and tick on the same edge: the write wins and the tick is discarded.
- Changing PERIOD restarts the prescaler; there is no partial period carry-over.
- With PERIOD=0 or 1, a tick occurs on every edge.
- MODE values are decoded only as listed above. No handshake: a write completes in one cycle and the block never stalls the CPU.

## Configuration
- `LED_PATTERN_CTRL_BOUNCE_EN` defined:
  - Mode 3 is the bounce behaviour described above.
  - `dir` is implemented and reported in STATUS bit 30.
- `LED_PATTERN_CTRL_BOUNCE_EN` undefined:
  - Mode 3 behaves exactly as mode 0 (direct).
  - `dir` is not implemented and STATUS bit 30 reads 0.
  - MODE still stores and reads back 3.

## Test plan
- Reset, then mode 0:
  - Assert `rst` 2 cycles -> `led_data`=0 and `read_data`=0 at all four addresses.
  - Write PATTERN=32'h0000_A5A5 -> `led_data`=16'hA5A5 after that edge; addr 0 reads 32'h0000A5A5.
- Blink:
  - Setup: PERIOD=4, MODE=1, PATTERN=16'h00FF.
  - Required: `led_data` alternates 16'h00FF/16'h0000 every 4 cycles.
  - After 3 ticks, STATUS reads {1, 0, 14'b0, 16'd3}.
- Rotate:
  - Setup: PERIOD=1, MODE=2, PATTERN=16'h8001.
  - Required: per-cycle `led_data` = 16'h0003, 16'h0006, 16'h000C.
  - After 16 ticks, `led_data` returns to 16'h8001.
- Bounce (macro defined):
  - Setup: PERIOD=1, MODE=3, PATTERN=16'h4000.
  - Required: `led_data` = 16'h8000, then 16'h4000 with STATUS bit 30=1; descends to 16'h0001; then 16'h0002 with bit 30=0.
  - Macro undefined, same stimulus: `led_data` holds 16'h4000.
- Collision and wrap:
  - Write PATTERN on the edge a tick is due -> `cnt` and `steps` restart at 0; no rotate is applied.
  - Steps wrap: after 65536 ticks at PERIOD=1, STATUS[15:0] reads 0.
- Reset mid-sequence:
  - Assert `rst` during mode 2 rotation -> next edge `led_data`=0, MODE reads 0, and no further ticks change `led_data`.
